// File: rtl/x2dn_response_monitor.sv
// x2dn_response_monitor
// Receives the x2dn output bus one sample per valid beat. For each fixed-length
// window it reports three registered results: the number of bit toggles between
// consecutive samples, a MISR signature of every sample, and a flag that is set
// when the toggle count saturated.
module x2dn_response_monitor #(
  parameter int               OUT_W     = 56,
  parameter int               WIN_LEN   = 256,
  parameter int               CNT_W     = 16,
  parameter logic [OUT_W-1:0] MISR_POLY = 56'h80_0000_0000_0095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OUT_W-1:0] in_vec,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_toggles,
  output logic [OUT_W-1:0] res_sig,
  output logic             res_sat,
  output logic             busy
);

  localparam int POP_W = $clog2(OUT_W + 1);
  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam int CW    = (WIN_LEN > 1) ? $clog2(WIN_LEN + 1) : 1;
  localparam logic [CW-1:0]    WIN_LAST = CW'(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_t;

  // One MISR step: shift left, fold the dropped MSB back through the taps, absorb the sample.
  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] v);
    misr_step = {s[OUT_W-2:0], 1'b0} ^ (s[OUT_W-1] ? MISR_POLY : {OUT_W{1'b0}}) ^ v;
  endfunction

  // Number of set bits in a sample.
  function automatic logic [POP_W-1:0] popcount(input logic [OUT_W-1:0] v);
    popcount = {POP_W{1'b0}};
    for (int i = 0; i < OUT_W; i++) begin
      popcount = popcount + POP_W'(v[i]);
    end
  endfunction

  state_t             state_r, state_nxt_s;
  logic               in_ready_r, res_valid_r, busy_r;
  logic               in_ready_nxt_s, res_valid_nxt_s, busy_nxt_s;
  logic [OUT_W-1:0]   prev_r;
  logic               has_prev_r;
  logic [OUT_W-1:0]   sig_r;
  logic [CW-1:0]      cnt_r;
  logic [CNT_W-1:0]   tog_r;
  logic               sat_r;
  logic [CNT_W-1:0]   res_tog_r;
  logic [OUT_W-1:0]   res_sig_r;
  logic               res_sat_r;

  logic               beat_s;
  logic [POP_W-1:0]   pop_s;
  logic [SUM_W-1:0]   sum_s;
  logic               over_s;
  logic [CNT_W-1:0]   tog_new_s;
  logic               sat_new_s;
  logic [OUT_W-1:0]   sig_new_s;
  logic [CW-1:0]      cnt_plus_s;

  // in_ready_r mirrors the current state, so a beat never depends combinationally on in_vec.
  assign beat_s     = in_valid & in_ready_r;
  assign pop_s      = has_prev_r ? popcount(in_vec ^ prev_r) : {POP_W{1'b0}};
  assign sum_s      = SUM_W'(tog_r) + SUM_W'(pop_s);
  assign over_s     = (sum_s > SUM_W'(CNT_MAX));
  assign tog_new_s  = over_s ? CNT_MAX : sum_s[CNT_W-1:0];
  assign sat_new_s  = sat_r | over_s;
  assign sig_new_s  = misr_step(sig_r, in_vec);
  assign cnt_plus_s = cnt_r + CW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: abort beats start, start beats the normal flow.
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = IDLE;
    end else if (start) begin
      state_nxt_s = PRIME;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        PRIME: begin
          if (beat_s) begin
            state_nxt_s = (WIN_LEN == 1) ? REPORT : RUN;
          end else begin
            state_nxt_s = PRIME;
          end
        end
        RUN: begin
          if (beat_s && (cnt_plus_s == WIN_LAST)) begin
            state_nxt_s = REPORT;
          end else begin
            state_nxt_s = RUN;
          end
        end
        REPORT: begin
          if (res_ready) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = REPORT;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // Output decode of the upcoming state, registered below so outputs change with the state.
  always_comb begin
    in_ready_nxt_s  = 1'b0;
    res_valid_nxt_s = 1'b0;
    busy_nxt_s      = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        busy_nxt_s = 1'b0;
      end
      PRIME, RUN: begin
        in_ready_nxt_s = 1'b1;
        busy_nxt_s     = 1'b1;
      end
      REPORT: begin
        res_valid_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  // Window datapath: reference vector, signature, beat count, toggle accumulator and result copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r     <= {OUT_W{1'b0}};
      has_prev_r <= 1'b0;
      sig_r      <= {OUT_W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      tog_r      <= {CNT_W{1'b0}};
      sat_r      <= 1'b0;
      res_tog_r  <= {CNT_W{1'b0}};
      res_sig_r  <= {OUT_W{1'b0}};
      res_sat_r  <= 1'b0;
    end else if (abort || start) begin
      // Both drop everything; start additionally re-arms through PRIME.
      prev_r     <= {OUT_W{1'b0}};
      has_prev_r <= 1'b0;
      sig_r      <= {OUT_W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      tog_r      <= {CNT_W{1'b0}};
      sat_r      <= 1'b0;
      res_tog_r  <= {CNT_W{1'b0}};
      res_sig_r  <= {OUT_W{1'b0}};
      res_sat_r  <= 1'b0;
    end else begin
      case (state_r)
        PRIME: begin
          if (beat_s) begin
            prev_r     <= in_vec;
            has_prev_r <= 1'b1;
            sig_r      <= misr_step({OUT_W{1'b0}}, in_vec);
            cnt_r      <= CW'(1);
            if (WIN_LEN == 1) begin
              res_tog_r <= tog_r;
              res_sig_r <= misr_step({OUT_W{1'b0}}, in_vec);
              res_sat_r <= sat_r;
            end
          end
        end
        RUN: begin
          if (beat_s) begin
            prev_r <= in_vec;
            sig_r  <= sig_new_s;
            cnt_r  <= cnt_plus_s;
            tog_r  <= tog_new_s;
            sat_r  <= sat_new_s;
            if (cnt_plus_s == WIN_LAST) begin
              res_tog_r <= tog_new_s;
              res_sig_r <= sig_new_s;
              res_sat_r <= sat_new_s;
            end
          end
        end
        REPORT: begin
          // prev_r is kept so the next window compares against the last sample of this one.
          if (res_ready) begin
            sig_r <= {OUT_W{1'b0}};
            cnt_r <= {CW{1'b0}};
            tog_r <= {CNT_W{1'b0}};
            sat_r <= 1'b0;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign res_valid   = res_valid_r;
  assign busy        = busy_r;
  assign res_toggles = res_tog_r;
  assign res_sig     = res_sig_r;
  assign res_sat     = res_sat_r;

endmodule
